// File: rtl/midi_voice_allocator.sv
// Purpose: maps MIDI note/sustain/all-notes-off events onto VOICES synth voices (retrigger, free, release-tail, steal).
// Latency: event accepted at t, one voice scanned per cycle t+1..t+VOICES, pulses/outputs in COMMIT at t+VOICES+1.
// Backpressure: evt_ready is high only in IDLE; the upstream holds evt_valid until it sees ready.
module midi_voice_allocator #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               CLOCK_25,
  input  logic               iRST_N,
  input  logic [15:0]        ch_mask,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic [1:0]         evt_type,
  input  logic [3:0]         evt_ch,
  input  logic [6:0]         evt_key,
  input  logic [6:0]         evt_val,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               stolen,
  output logic [V_WIDTH:0]   active_keys
);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

  state_t               state;
  logic [V_WIDTH-1:0]   scan_idx;
  logic [1:0]           e_type;
  logic [3:0]           e_ch;
  logic [6:0]           e_key, e_val;

  // Voice table; a voice is gated while it is held or sustained, so keys_on is derived from both flags.
  logic [6:0]           v_key  [VOICES];
  logic [3:0]           v_ch   [VOICES];
  logic [V_WIDTH-1:0]   v_rank [VOICES];
  logic [VOICES-1:0]    v_held, v_sust;
  logic [15:0]          sustain;

  // Scan accumulators: retrigger match, first free voice, oldest ungated, oldest gated.
  logic                 rt_f, fr_f, rl_f, og_f;
  logic [V_WIDTH-1:0]   rt_i, fr_i, rl_i, og_i, rl_r, og_r;
  logic                 a_rt_f, a_fr_f, a_rl_f, a_og_f;
  logic [V_WIDTH-1:0]   a_rt_i, a_fr_i, a_rl_i, a_og_i, a_rl_r, a_og_r;

  // Commit results.
  logic [6:0]           n_key  [VOICES];
  logic [3:0]           n_ch   [VOICES];
  logic [V_WIDTH-1:0]   n_rank [VOICES];
  logic [VOICES-1:0]    n_held, n_sust, n_keys;
  logic [15:0]          n_sustain;
  logic                 p_on, p_off, p_stl, dropped;
  logic [V_WIDTH-1:0]   p_adr, sel;
  logic [7:0]           p_kv, p_von, p_voff;
  logic [V_WIDTH:0]     n_active;

  assign keys_on = v_held | v_sust;
  assign n_keys  = n_held | n_sust;

  // Fold the voice under the scan pointer into the accumulators; voice_free is sampled here only.
  always_comb begin
    a_rt_f = rt_f; a_rt_i = rt_i;
    a_fr_f = fr_f; a_fr_i = fr_i;
    a_rl_f = rl_f; a_rl_i = rl_i; a_rl_r = rl_r;
    a_og_f = og_f; a_og_i = og_i; a_og_r = og_r;
    if (!rt_f && keys_on[scan_idx] && v_ch[scan_idx] == e_ch && v_key[scan_idx] == e_key) begin
      a_rt_f = 1'b1; a_rt_i = scan_idx;
    end
    if (!fr_f && voice_free[scan_idx] && !keys_on[scan_idx]) begin
      a_fr_f = 1'b1; a_fr_i = scan_idx;
    end
    if (!keys_on[scan_idx] && (!rl_f || v_rank[scan_idx] > rl_r)) begin
      a_rl_f = 1'b1; a_rl_i = scan_idx; a_rl_r = v_rank[scan_idx];
    end
    if (keys_on[scan_idx] && (!og_f || v_rank[scan_idx] > og_r)) begin
      a_og_f = 1'b1; a_og_i = scan_idx; a_og_r = v_rank[scan_idx];
    end
  end

  // Compute the table update and pulses applied at the end of the last scan cycle.
  always_comb begin
    n_key = v_key; n_ch = v_ch; n_rank = v_rank;
    n_held = v_held; n_sust = v_sust; n_sustain = sustain;
    p_on = 1'b0; p_off = 1'b0; p_stl = 1'b0; dropped = 1'b0; sel = '0;
    p_adr = cur_key_adr; p_kv = cur_key_val; p_von = cur_vel_on; p_voff = cur_vel_off;
    if (ch_mask[e_ch]) begin
      if (e_type == 2'b01 && e_val != 7'd0) begin
        if (a_rt_f)      sel = a_rt_i;
        else if (a_fr_f) sel = a_fr_i;
        else if (a_rl_f) sel = a_rl_i;
        else begin
          sel   = a_og_i;
          p_stl = 1'b1;
        end
        for (int i = 0; i < VOICES; i++)
          if (v_rank[i] < v_rank[sel]) n_rank[i] = v_rank[i] + 1'b1;
        n_rank[sel] = '0;
        n_key[sel]  = e_key;
        n_ch[sel]   = e_ch;
        n_held[sel] = 1'b1;
        n_sust[sel] = 1'b0;
        p_on  = 1'b1;
        p_adr = sel;
        p_kv  = {1'b0, e_key};
        p_von = {1'b0, e_val};
      end else if (e_type[1] == 1'b0) begin
        // Note-off, including note-on with zero velocity.
        for (int i = 0; i < VOICES; i++) begin
          if (keys_on[i] && v_ch[i] == e_ch && v_key[i] == e_key) begin
            n_held[i] = 1'b0;
            if (sustain[e_ch]) n_sust[i] = 1'b1;
            else begin
              n_sust[i] = 1'b0;
              if (!dropped) p_adr = V_WIDTH'(i);
              dropped = 1'b1;
            end
          end
        end
        if (dropped) begin
          p_off  = 1'b1;
          p_kv   = {1'b0, e_key};
          p_voff = {1'b0, e_val};
        end
      end else if (e_type == 2'b10) begin
        n_sustain[e_ch] = e_val[6];
        if (sustain[e_ch] && !e_val[6]) begin
          for (int i = 0; i < VOICES; i++) begin
            if (v_sust[i] && v_ch[i] == e_ch) begin
              n_sust[i] = 1'b0;
              if (!dropped) begin
                p_adr = V_WIDTH'(i);
                p_kv  = {1'b0, v_key[i]};
              end
              dropped = 1'b1;
            end
          end
        end
        if (dropped) begin
          p_off  = 1'b1;
          p_voff = 8'd0;
        end
      end else begin
        for (int i = 0; i < VOICES; i++) begin
          if (v_ch[i] == e_ch) begin
            if (keys_on[i] && !dropped) begin
              p_adr = V_WIDTH'(i);
              p_kv  = {1'b0, v_key[i]};
            end
            dropped   = dropped | keys_on[i];
            n_held[i] = 1'b0;
            n_sust[i] = 1'b0;
          end
        end
        if (dropped) begin
          p_off  = 1'b1;
          p_voff = 8'd0;
        end
      end
    end
  end

  // Popcount of the post-commit gate vector.
  always_comb begin
    n_active = '0;
    for (int i = 0; i < VOICES; i++) n_active = n_active + (V_WIDTH+1)'(n_keys[i]);
  end

  // Control FSM, voice table and registered outputs.
  always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE; evt_ready <= 1'b1; scan_idx <= '0;
      e_type <= '0; e_ch <= '0; e_key <= '0; e_val <= '0;
      rt_f <= 1'b0; fr_f <= 1'b0; rl_f <= 1'b0; og_f <= 1'b0;
      rt_i <= '0; fr_i <= '0; rl_i <= '0; og_i <= '0; rl_r <= '0; og_r <= '0;
      v_held <= '0; v_sust <= '0; sustain <= '0;
      for (int i = 0; i < VOICES; i++) begin
        v_key[i]  <= '0;
        v_ch[i]   <= '0;
        v_rank[i] <= V_WIDTH'(i);
      end
      note_on <= 1'b0; note_off <= 1'b0; stolen <= 1'b0;
      cur_key_adr <= '0; cur_key_val <= '0; cur_vel_on <= '0; cur_vel_off <= '0;
      active_keys <= '0;
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      stolen   <= 1'b0;
      case (state)
        IDLE: if (evt_valid) begin
          e_type <= evt_type; e_ch <= evt_ch; e_key <= evt_key; e_val <= evt_val;
          rt_f <= 1'b0; fr_f <= 1'b0; rl_f <= 1'b0; og_f <= 1'b0;
          scan_idx  <= '0;
          evt_ready <= 1'b0;
          state     <= SCAN;
        end
        SCAN: begin
          rt_f <= a_rt_f; rt_i <= a_rt_i; fr_f <= a_fr_f; fr_i <= a_fr_i;
          rl_f <= a_rl_f; rl_i <= a_rl_i; rl_r <= a_rl_r;
          og_f <= a_og_f; og_i <= a_og_i; og_r <= a_og_r;
          if (scan_idx == LAST) begin
            v_key <= n_key; v_ch <= n_ch; v_rank <= n_rank;
            v_held <= n_held; v_sust <= n_sust; sustain <= n_sustain;
            note_on <= p_on; note_off <= p_off; stolen <= p_stl;
            cur_key_adr <= p_adr; cur_key_val <= p_kv;
            cur_vel_on  <= p_von; cur_vel_off <= p_voff;
            active_keys <= n_active;
            state <= COMMIT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        COMMIT: begin
          evt_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: random events against an age-list reference model, scoreboard checked at COMMIT.
// Each transaction is expected to keep evt_ready low for VOICES+1 cycles with pulses only in the last one.
// Stimulus waits for evt_ready before offering; voice_free/ch_mask only change while the DUT is idle.
module tb_midi_voice_allocator;
  localparam int V = 8;

  logic         CLOCK_25 = 1'b0;
  logic         iRST_N = 1'b0;
  logic [15:0]  ch_mask = 16'hFFFF;
  logic         evt_valid = 1'b0;
  logic         evt_ready;
  logic [1:0]   evt_type = '0;
  logic [3:0]   evt_ch = '0;
  logic [6:0]   evt_key = '0;
  logic [6:0]   evt_val = '0;
  logic [V-1:0] voice_free = '1;
  logic [V-1:0] keys_on;
  logic         note_on, note_off, stolen;
  logic [2:0]   cur_key_adr;
  logic [7:0]   cur_key_val, cur_vel_on, cur_vel_off;
  logic [3:0]   active_keys;

  midi_voice_allocator #(.VOICES(V)) dut (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .ch_mask(ch_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_ch(evt_ch), .evt_key(evt_key), .evt_val(evt_val),
    .voice_free(voice_free), .keys_on(keys_on), .note_on(note_on),
    .note_off(note_off), .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off), .stolen(stolen),
    .active_keys(active_keys)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  typedef struct {
    bit       on, off, stl;
    int       adr;
    bit [7:0] kv, von, voff;
    bit [V-1:0] keys;
    int       act;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   busy = 0;
  bit   mon_en = 1'b0;

  // Reference model: per-voice state plus an age list (front = youngest).
  bit [6:0] m_key [V];
  bit [3:0] m_ch  [V];
  bit       m_held[V], m_sust[V];
  bit       m_sus_ch[16];
  int       age[$];
  int       m_adr;
  bit [7:0] m_kv, m_von, m_voff;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit gated(int i);
    return m_held[i] | m_sust[i];
  endfunction

  task automatic m_reset();
    age.delete();
    for (int i = 0; i < V; i++) begin
      m_key[i] = 0; m_ch[i] = 0; m_held[i] = 0; m_sust[i] = 0;
      age.push_back(i);
    end
    for (int c = 0; c < 16; c++) m_sus_ch[c] = 0;
    m_adr = 0; m_kv = 0; m_von = 0; m_voff = 0;
  endtask

  task automatic model_evt(input bit [1:0] t, input bit [3:0] ch, input bit [6:0] k, input bit [6:0] v);
    exp_t e;
    int   c;
    bit   found;
    e.on = 0; e.off = 0; e.stl = 0;
    found = 0;
    if (ch_mask[ch]) begin
      if (t == 2'd1 && v != 0) begin
        c = -1;
        for (int i = 0; i < V; i++) if (c < 0 && gated(i) && m_ch[i] == ch && m_key[i] == k) c = i;
        for (int i = 0; i < V; i++) if (c < 0 && voice_free[i] && !gated(i)) c = i;
        for (int j = age.size() - 1; j >= 0; j--) if (c < 0 && !gated(age[j])) c = age[j];
        if (c < 0) begin
          c = age[age.size() - 1];
          e.stl = 1;
        end
        for (int j = 0; j < age.size(); j++) if (age[j] == c) begin age.delete(j); break; end
        age.push_front(c);
        m_key[c] = k; m_ch[c] = ch; m_held[c] = 1; m_sust[c] = 0;
        e.on = 1; m_adr = c; m_kv = {1'b0, k}; m_von = {1'b0, v};
      end else if (t[1] == 1'b0) begin
        for (int i = 0; i < V; i++) begin
          if (gated(i) && m_ch[i] == ch && m_key[i] == k) begin
            m_held[i] = 0;
            if (m_sus_ch[ch]) m_sust[i] = 1;
            else if (!found) begin found = 1; m_adr = i; end
          end
        end
        if (found && !m_sus_ch[ch]) begin
          e.off = 1; m_kv = {1'b0, k}; m_voff = {1'b0, v};
        end
      end else if (t == 2'd2) begin
        if (m_sus_ch[ch] && v < 64) begin
          for (int i = 0; i < V; i++) begin
            if (m_sust[i] && m_ch[i] == ch) begin
              m_sust[i] = 0;
              if (!found) begin found = 1; m_adr = i; m_kv = {1'b0, m_key[i]}; end
            end
          end
          if (found) begin e.off = 1; m_voff = 0; end
        end
        m_sus_ch[ch] = (v >= 64);
      end else begin
        for (int i = 0; i < V; i++) begin
          if (m_ch[i] == ch) begin
            if (gated(i) && !found) begin found = 1; m_adr = i; m_kv = {1'b0, m_key[i]}; end
            m_held[i] = 0; m_sust[i] = 0;
          end
        end
        if (found) begin e.off = 1; m_voff = 0; end
      end
    end
    e.adr = m_adr; e.kv = m_kv; e.von = m_von; e.voff = m_voff;
    e.act = 0;
    for (int i = 0; i < V; i++) begin
      e.keys[i] = gated(i);
      e.act += gated(i);
    end
    sb.push_back(e);
  endtask

  // Monitor: counts busy cycles; the last busy cycle is the commit and is checked against the scoreboard.
  always @(negedge CLOCK_25) begin
    if (mon_en) begin
      if (!evt_ready) begin
        busy++;
        if (busy == V + 1) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: commit seen with no expected event at %0t", $time);
          end else begin
            mon_e = sb.pop_front();
            chk("note_on",     note_on,     mon_e.on);
            chk("note_off",    note_off,    mon_e.off);
            chk("stolen",      stolen,      mon_e.stl);
            chk("cur_key_adr", cur_key_adr, mon_e.adr);
            chk("cur_key_val", cur_key_val, mon_e.kv);
            chk("cur_vel_on",  cur_vel_on,  mon_e.von);
            chk("cur_vel_off", cur_vel_off, mon_e.voff);
            chk("keys_on",     keys_on,     mon_e.keys);
            chk("active_keys", active_keys, mon_e.act);
          end
        end else begin
          chk("no_pulse_while_scanning", {note_on, note_off, stolen}, 0);
        end
      end else if (busy != 0) begin
        chk("ready_low_cycles", busy, V + 1);
        busy = 0;
      end
    end
  end

  task automatic send(input bit [1:0] t, input bit [3:0] ch, input bit [6:0] k, input bit [6:0] v,
                      input bit [V-1:0] vf, input bit [15:0] mask);
    int w;
    w = 0;
    @(negedge CLOCK_25);
    while (!evt_ready && w < 100) begin
      @(negedge CLOCK_25);
      w++;
    end
    if (!evt_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: evt_ready=%0b required 1", evt_ready);
      return;
    end
    voice_free = vf; ch_mask = mask;
    evt_type = t; evt_ch = ch; evt_key = k; evt_val = v; evt_valid = 1'b1;
    model_evt(t, ch, k, v);
    @(posedge CLOCK_25);
    #1 evt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge CLOCK_25);
      w++;
    end while (!(evt_ready && sb.size() == 0) && w < 200);
    if (!(evt_ready && sb.size() == 0)) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: ready=%0b pending=%0d required ready=1 pending=0", evt_ready, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [1:0]   t;
    bit [6:0]   v;
    bit [V-1:0] vf;
    bit [15:0]  mask;
    int r;
    m_reset();
    repeat (3) @(negedge CLOCK_25);
    iRST_N = 1'b1;
    @(negedge CLOCK_25);
    chk("rst_keys_on",     keys_on,     0);
    chk("rst_pulses",      {note_on, note_off, stolen}, 0);
    chk("rst_cur_key_adr", cur_key_adr, 0);
    chk("rst_cur_key_val", cur_key_val, 0);
    chk("rst_cur_vel",     {cur_vel_on, cur_vel_off}, 0);
    chk("rst_active_keys", active_keys, 0);
    chk("rst_evt_ready",   evt_ready,   1);
    mon_en = 1'b1;

    // First note lands on voice 0.
    send(2'd1, 4'd0, 7'd60, 7'd100, '1, 16'hFFFF);
    wait_idle();
    chk("first_keys_on", keys_on, 8'h01);
    chk("first_vel_on",  cur_vel_on, 8'd100);

    // Same key again retriggers voice 0.
    send(2'd1, 4'd0, 7'd60, 7'd90, '1, 16'hFFFF);
    wait_idle();
    chk("retrig_keys_on", keys_on, 8'h01);
    chk("retrig_adr",     cur_key_adr, 0);

    // Sustain holds the gate through note-off, release drops it.
    send(2'd2, 4'd0, 7'd0, 7'd127, '1, 16'hFFFF);
    send(2'd0, 4'd0, 7'd60, 7'd40, '1, 16'hFFFF);
    wait_idle();
    chk("sustained_keys_on", keys_on, 8'h01);
    send(2'd2, 4'd0, 7'd0, 7'd0, '1, 16'hFFFF);
    wait_idle();
    chk("released_keys_on", keys_on, 8'h00);

    // Fill all voices, then steal the oldest.
    for (int k = 0; k < V; k++) send(2'd1, 4'd0, 7'(60 + k), 7'd64, '1, 16'hFFFF);
    send(2'd1, 4'd0, 7'd70, 7'd77, '0, 16'hFFFF);
    wait_idle();
    chk("steal_keys_on", keys_on, 8'hFF);
    chk("steal_active",  active_keys, 8);
    chk("steal_adr",     cur_key_adr, 0);
    chk("steal_key",     cur_key_val, 70);

    // Masked channel changes nothing.
    send(2'd1, 4'd3, 7'd50, 7'd50, '1, 16'h0001);
    wait_idle();
    chk("masked_keys_on", keys_on, 8'hFF);

    // All-notes-off on channel 0.
    send(2'd3, 4'd0, 7'd0, 7'd0, '0, 16'hFFFF);
    wait_idle();
    chk("ano_keys_on", keys_on, 8'h00);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       t = 2'd1;
      else if (r < 14) t = 2'd0;
      else if (r < 18) t = 2'd2;
      else             t = 2'd3;
      v = 7'($urandom_range(0, 127));
      if (t == 2'd1 && $urandom_range(0, 9) == 0) v = 7'd0;
      if (t == 2'd2) v = ($urandom_range(0, 1) == 1) ? 7'd127 : 7'($urandom_range(0, 63));
      vf   = ($urandom_range(0, 2) == 0) ? '0 : V'($urandom);
      mask = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF;
      send(t, 4'($urandom_range(0, 3)), 7'(60 + $urandom_range(0, 9)), v, vf, mask);
    end
    wait_idle();

    // Reset in the middle of a scan.
    send(2'd1, 4'd1, 7'd61, 7'd10, '1, 16'hFFFF);
    wait_idle();
    mon_en = 1'b0;
    send(2'd1, 4'd0, 7'd72, 7'd80, '0, 16'hFFFF);
    repeat (3) @(negedge CLOCK_25);
    iRST_N = 1'b0;
    @(negedge CLOCK_25);
    chk("midrst_keys_on", keys_on, 0);
    chk("midrst_active",  active_keys, 0);
    chk("midrst_pulses",  {note_on, note_off, stolen}, 0);
    iRST_N = 1'b1;
    @(negedge CLOCK_25);
    chk("midrst_ready_after", evt_ready, 1);
    for (int i = 0; i < V + 2; i++) begin
      chk("midrst_no_pulse", {note_on, note_off, stolen, keys_on}, 0);
      @(negedge CLOCK_25);
    end
    sb.delete();
    m_reset();
    busy = 0;
    mon_en = 1'b1;
    send(2'd1, 4'd2, 7'd65, 7'd33, '1, 16'hFFFF);
    wait_idle();
    chk("post_rst_keys_on", keys_on, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
